// File: rtl/memory_block_transfer.sv
// Moves one cache block between a word-wide memory and the cache buffer, one word per access,
// with a single idle gap cycle between word accesses so the memory can reload its delay counter.
module memory_block_transfer #(
    parameter int unsigned ADDRESS_WIDTH   = 16,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned WORDS_PER_BLOCK = 8,
    parameter int unsigned OFFSET_WIDTH    = $clog2(WORDS_PER_BLOCK)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  request_read_i,
    input  logic                                  request_write_i,
    input  logic [ADDRESS_WIDTH-OFFSET_WIDTH-1:0] block_address_i,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic [OFFSET_WIDTH-1:0]               buffer_index_o,
    input  logic [DATA_WIDTH-1:0]                 buffer_read_data_i,
    output logic [DATA_WIDTH-1:0]                 buffer_write_data_o,
    output logic                                  buffer_write_enable_o,
    output logic [ADDRESS_WIDTH-1:0]              address_o,
    output logic [DATA_WIDTH-1:0]                 data_out_o,
    input  logic [DATA_WIDTH-1:0]                 data_in_i,
    output logic                                  read_enabled_o,
    output logic                                  write_enabled_o,
    input  logic                                  function_complete_i
);

    typedef enum logic [1:0] {StIdle, StAccess, StGap, StDone} state_e;

    localparam logic [OFFSET_WIDTH-1:0] LastOffset = OFFSET_WIDTH'(WORDS_PER_BLOCK - 1);

    state_e                            state_q;
    logic                              write_q;
    logic                              busy_q;
    logic                              done_q;
    logic                              read_en_q;
    logic                              write_en_q;
    logic [OFFSET_WIDTH-1:0]           offset_q;
    logic [ADDRESS_WIDTH-OFFSET_WIDTH-1:0] block_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            write_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            read_en_q  <= 1'b0;
            write_en_q <= 1'b0;
            offset_q   <= '0;
            block_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Write-back wins when both requests arrive together.
                    if (request_write_i || request_read_i) begin
                        write_q    <= request_write_i;
                        block_q    <= block_address_i;
                        offset_q   <= '0;
                        busy_q     <= 1'b1;
                        read_en_q  <= ~request_write_i;
                        write_en_q <= request_write_i;
                        state_q    <= StAccess;
                    end
                end
                StAccess: begin
                    if (function_complete_i) begin
                        read_en_q  <= 1'b0;
                        write_en_q <= 1'b0;
                        state_q    <= StGap;
                    end
                end
                StGap: begin
                    if (offset_q == LastOffset) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        offset_q   <= offset_q + OFFSET_WIDTH'(1);
                        read_en_q  <= ~write_q;
                        write_en_q <= write_q;
                        state_q    <= StAccess;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o                = busy_q;
    assign done_o                = done_q;
    assign read_enabled_o        = read_en_q;
    assign write_enabled_o       = write_en_q;
    assign buffer_index_o        = offset_q;
    assign address_o             = {block_q, offset_q};
    assign buffer_write_enable_o = read_en_q & function_complete_i;
    assign buffer_write_data_o   = data_in_i;
    assign data_out_o            = write_en_q ? buffer_read_data_i : '0;

endmodule

// File: doc/memory_block_transfer.md
MEMORY_BLOCK_TRANSFER -- requirements
Module: memory_block_transfer

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 16, meaning the word address width on the memory side.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the word width.
REQ-003 The block SHALL have parameter WORDS_PER_BLOCK, default 8, a power of two >= 2, meaning the words per cache block.
REQ-004 The block SHALL have parameter OFFSET_WIDTH, default log2(WORDS_PER_BLOCK) = 3, meaning the in-block word offset width.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset: clock  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous, active-low.
REQ-007 requestRead  in  1  cache requests a block fill (memory -> cache).
REQ-008 requestWrite  in  1  cache requests a block write-back (cache -> memory).
REQ-009 blockAddress  in  ADDRESS_WIDTH-OFFSET_WIDTH  block number; sampled on accept.
REQ-010 busy  out  1  high while a transfer is in progress.
REQ-011 done  out  1  one-cycle pulse when a transfer finishes.
REQ-012 bufferIndex  out  OFFSET_WIDTH  current word offset into the cache block.
REQ-013 bufferReadData  in  DATA_WIDTH  cache word at bufferIndex, combinational, used for write-back.
REQ-014 bufferWriteData  out  DATA_WIDTH  word to store into the cache during a fill.
REQ-015 bufferWriteEnable  out  1  one-cycle strobe that stores bufferWriteData at bufferIndex.
REQ-016 address  out  ADDRESS_WIDTH  memory word address, equal to {latched blockAddress, bufferIndex}.
REQ-017 dataOut  out  DATA_WIDTH  memory write data, equal to bufferReadData during write ACCESS and 0 otherwise.
REQ-018 dataIn  in  DATA_WIDTH  memory read data, valid when functionComplete=1.
REQ-019 readEnabled, writeEnabled  out  1 each  memory command strobes; at most one is high at any time.
REQ-020 functionComplete  in  1  memory reports that the current word access is complete.

Function
REQ-021 The block SHALL implement the states IDLE, ACCESS, GAP and DONE.
REQ-022 In IDLE, the block SHALL accept a request when requestWrite or requestRead is high, latch blockAddress and the direction, set the offset to 0, and go to ACCESS on the next cycle.
REQ-023 If requestWrite and requestRead are high together in IDLE, the block SHALL perform the write-back and ignore the read.
REQ-024 The block SHALL ignore requests outside IDLE; they are neither queued nor acknowledged.
REQ-025 In ACCESS, the block SHALL hold the selected enable high and keep address and dataOut stable until functionComplete=1.
REQ-026 In the ACCESS cycle with functionComplete=1 on a read, the block SHALL pulse bufferWriteEnable with bufferWriteData=dataIn and bufferIndex equal to the current offset.
REQ-027 On completion of each word, the block SHALL go to GAP for exactly one cycle with both enables low, so the memory reloads its delay counter.
REQ-028 The block SHALL never issue back-to-back enabled cycles on different addresses.
REQ-029 In GAP, if the offset is WORDS_PER_BLOCK-1 the block SHALL go to DONE; otherwise it SHALL increment the offset and return to ACCESS.
REQ-030 In DONE, the block SHALL hold done=1 and busy=1 for one cycle, then go to IDLE.
REQ-031 busy SHALL be 1 in ACCESS, GAP and DONE, and 0 in IDLE.
REQ-032 Offset arithmetic SHALL be modulo 2^OFFSET_WIDTH and SHALL never wrap inside a transfer.
REQ-033 The address high bits SHALL stay constant for the whole transfer even if blockAddress changes.
REQ-034 A functionComplete=1 seen in IDLE, GAP or DONE SHALL be ignored.
REQ-035 The per-word cost SHALL be the memory access time plus one GAP cycle, with no other added wait states.

Reset
REQ-036 While reset=0, the block SHALL enter IDLE immediately, independent of clock, with busy, done, readEnabled, writeEnabled and bufferWriteEnable = 0, offset = 0, latched address = 0 and dataOut = 0.
REQ-037 Reset in the middle of a transfer SHALL abort it with no done pulse and no further bufferWriteEnable.
REQ-038 After reset is released, the block SHALL accept a new request on the first rising edge.

Verification
REQ-039 Fill test: memory with DELAY=4 preloaded with mem[i]=i, blockAddress=5, requestRead for 1 cycle -> 8 bufferWriteEnable pulses, each writing index k with data 40+k; every word takes 5 ACCESS cycles plus 1 GAP cycle; done pulses once, 49 cycles after the request cycle.
REQ-040 Write-back test: bufferReadData=0xA0+index, blockAddress=2, requestWrite -> memory words 16..23 = 0xA0..0xA7; readEnabled never asserted.
REQ-041 Simultaneous-request test: requestRead=requestWrite=1 -> write-back only; no bufferWriteEnable pulses.
REQ-042 Busy-request test: requestRead pulsed during ACCESS of word 3 -> no effect; exactly one done pulse.
REQ-043 Reset-mid-transfer test: reset=0 during ACCESS of word 4 -> enables drop in the same cycle and no done pulse; a new requestRead after release completes normally.
REQ-044 Protocol-checker assertion: readEnabled and writeEnabled are never both 1, and every enabled run is followed by at least one cycle with both enables 0 before address changes.
